// File: rtl/ifu_prefetch_pkg.sv
// Shared fetch-side definitions: datapath widths, the fetch stride, the memory
// request tag layout {epoch, pc} and the prefetch FIFO entry layout {instr, pc}.
package ifu_prefetch_pkg;

    localparam int XLEN                 = 32;
    localparam int INSTR_LEN            = 32;
    localparam int INSTR_MEM_WIDTH      = 32;
    localparam int INSTR_MEM_ADDR_WIDTH = 16;
    localparam int TAG_WIDTH            = XLEN + 1;

    localparam logic [XLEN-1:0] FETCH_STEP = 32'd4;

    // Tag carried with every memory request; epoch sits in the MSB.
    typedef struct packed {
        logic            epoch;
        logic [XLEN-1:0] pc;
    } fetch_tag_t;

    // One prefetched instruction together with the PC it was fetched from.
    typedef struct packed {
        logic [INSTR_LEN-1:0] instr;
        logic [XLEN-1:0]      pc;
    } fetch_entry_t;

    // Redirect targets are forced onto a word boundary.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifu_prefetch_fifo.sv
// fetch_fifo: synchronous FIFO holding prefetched {instr, pc} entries.
// Ports: clk/rstn, push/din write side, pop/dout read side (dout reads zero
// when empty), flush empties the FIFO and wins over push/pop, count/empty/full
// report occupancy. Pushes when full and pops when empty are ignored.
module fetch_fifo #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;
    logic             empty_s;
    logic             full_s;

    // Occupancy flags and qualified push/pop strobes.
    always_comb begin
        empty_s   = (count_r == {CW{1'b0}});
        full_s    = (count_r == CW'(DEPTH));
        do_push_s = push & ~full_s;
        do_pop_s  = pop & ~empty_s;
    end

    // Storage, pointers (wrap naturally, DEPTH is a power of two) and count.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + AW'(1'b1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Head entry is presented as zero while the FIFO is empty.
    always_comb begin
        if (empty_s) begin
            dout = {WIDTH{1'b0}};
        end else begin
            dout = mem_r[rd_ptr_r];
        end
    end

    assign count = count_r;
    assign empty = empty_s;
    assign full  = full_s;

endmodule

// File: rtl/ifu_prefetch.sv
// ifu_prefetch: instruction prefetcher between instruction memory and decode.
// Ports: clk/rstn; reset_vector start PC; instr_mem_addr/_valid/_ready/_tag_out
// request channel; instr_mem_rdata/_valid/_tag_in in-order response channel;
// pc_exu/pc_load redirect; pipe_stall decode back-pressure; instr/instr_valid/
// instr_tag head of the prefetch FIFO.
// A request is only issued when the sum of in-flight requests and buffered
// instructions leaves room, so every returning response has a slot.
module ifu_prefetch
    import ifu_prefetch_pkg::*;
#(
    parameter int FETCH_DEPTH     = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic [XLEN-1:0]                 reset_vector,
    output logic [INSTR_MEM_ADDR_WIDTH-1:0] instr_mem_addr,
    output logic                            instr_mem_addr_valid,
    input  logic                            instr_mem_addr_ready,
    output logic [TAG_WIDTH-1:0]            instr_mem_tag_out,
    input  logic [INSTR_MEM_WIDTH-1:0]      instr_mem_rdata,
    input  logic                            instr_mem_rdata_valid,
    input  logic [TAG_WIDTH-1:0]            instr_mem_tag_in,
    input  logic [XLEN-1:0]                 pc_exu,
    input  logic                            pc_load,
    input  logic                            pipe_stall,
    output logic [INSTR_LEN-1:0]            instr,
    output logic                            instr_valid,
    output logic [XLEN-1:0]                 instr_tag
);

    localparam int IW = $clog2(MAX_OUTSTANDING + 1);
    localparam int CW = $clog2(FETCH_DEPTH + 1);
    localparam int OW = $clog2(FETCH_DEPTH + MAX_OUTSTANDING + 1);

    logic [XLEN-1:0] pc_r;
    logic            epoch_r;
    logic [IW-1:0]   inflight_r;

    logic [CW-1:0]   fifo_count_s;
    logic            fifo_empty_s;
    logic            fifo_full_s;
    fetch_entry_t    fifo_dout_s;
    fetch_entry_t    push_entry_s;
    fetch_tag_t      resp_tag_s;
    logic [OW-1:0]   occ_s;
    logic            credit_ok_s;
    logic            addr_valid_s;
    logic            issue_s;
    logic            push_s;
    logic            pop_s;

    // Credit check, handshakes and response filtering. A redirect blocks issue,
    // drops any response of that cycle and suppresses the pop (FIFO flushes).
    always_comb begin
        resp_tag_s         = fetch_tag_t'(instr_mem_tag_in);
        occ_s              = OW'(inflight_r) + OW'(fifo_count_s);
        credit_ok_s        = (occ_s < OW'(FETCH_DEPTH)) && (inflight_r < IW'(MAX_OUTSTANDING));
        addr_valid_s       = rstn & ~pc_load & credit_ok_s;
        issue_s            = addr_valid_s & instr_mem_addr_ready;
        push_s             = instr_mem_rdata_valid & (resp_tag_s.epoch == epoch_r)
                             & ~pc_load & ~fifo_full_s;
        pop_s              = ~fifo_empty_s & ~pipe_stall & ~pc_load;
        push_entry_s.instr = instr_mem_rdata[INSTR_LEN-1:0];
        push_entry_s.pc    = resp_tag_s.pc;
    end

    // PC, epoch and in-flight counter. Stale responses still release credit.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_r       <= reset_vector;
            epoch_r    <= 1'b0;
            inflight_r <= {IW{1'b0}};
        end else begin
            if (pc_load) begin
                pc_r    <= align_pc(pc_exu);
                epoch_r <= ~epoch_r;
            end else if (issue_s) begin
                pc_r    <= pc_r + FETCH_STEP;
            end
            case ({issue_s, instr_mem_rdata_valid})
                2'b10:   inflight_r <= inflight_r + IW'(1'b1);
                2'b01:   inflight_r <= inflight_r - IW'(1'b1);
                default: inflight_r <= inflight_r;
            endcase
        end
    end

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (FETCH_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push_s),
        .pop   (pop_s),
        .flush (pc_load),
        .din   (push_entry_s),
        .dout  (fifo_dout_s),
        .count (fifo_count_s),
        .empty (fifo_empty_s),
        .full  (fifo_full_s)
    );

    assign instr_mem_addr       = pc_r[INSTR_MEM_ADDR_WIDTH-1:0];
    assign instr_mem_addr_valid = addr_valid_s;
    assign instr_mem_tag_out    = {epoch_r, pc_r};
    assign instr                = fifo_dout_s.instr;
    assign instr_tag            = fifo_dout_s.pc;
    assign instr_valid          = ~fifo_empty_s;

endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed testbench for ifu_prefetch with an in-order, fixed-latency
// instruction memory model. Returned instruction word = pc ^ 0x5A5A0000.
module tb_ifu_prefetch;
    import ifu_prefetch_pkg::*;

    logic                            clk = 1'b0;
    logic                            rstn;
    logic [XLEN-1:0]                 reset_vector;
    logic [INSTR_MEM_ADDR_WIDTH-1:0] instr_mem_addr;
    logic                            instr_mem_addr_valid;
    logic                            instr_mem_addr_ready;
    logic [TAG_WIDTH-1:0]            instr_mem_tag_out;
    logic [INSTR_MEM_WIDTH-1:0]      instr_mem_rdata;
    logic                            instr_mem_rdata_valid;
    logic [TAG_WIDTH-1:0]            instr_mem_tag_in;
    logic [XLEN-1:0]                 pc_exu;
    logic                            pc_load;
    logic                            pipe_stall;
    logic [INSTR_LEN-1:0]            instr;
    logic                            instr_valid;
    logic [XLEN-1:0]                 instr_tag;

    ifu_prefetch #(.FETCH_DEPTH(4), .MAX_OUTSTANDING(2)) dut (
        .clk                   (clk),
        .rstn                  (rstn),
        .reset_vector          (reset_vector),
        .instr_mem_addr        (instr_mem_addr),
        .instr_mem_addr_valid  (instr_mem_addr_valid),
        .instr_mem_addr_ready  (instr_mem_addr_ready),
        .instr_mem_tag_out     (instr_mem_tag_out),
        .instr_mem_rdata       (instr_mem_rdata),
        .instr_mem_rdata_valid (instr_mem_rdata_valid),
        .instr_mem_tag_in      (instr_mem_tag_in),
        .pc_exu                (pc_exu),
        .pc_load               (pc_load),
        .pipe_stall            (pipe_stall),
        .instr                 (instr),
        .instr_valid           (instr_valid),
        .instr_tag             (instr_tag)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    typedef struct {
        logic [TAG_WIDTH-1:0] tag;
        int                   due;
    } req_t;

    req_t q[$];
    int   cyc     = 0;
    int   lat     = 1;
    int   max_out = 0;
    int   n_vec   = 0;
    int   n_err   = 0;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ 32'h5A5A_0000;
    endfunction

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: present a due response, record handshakes, step the edge.
    task automatic tick();
        if (q.size() > 0 && q[0].due <= cyc) begin
            instr_mem_rdata_valid = 1'b1;
            instr_mem_tag_in      = q[0].tag;
            instr_mem_rdata       = instr_of(q[0].tag[31:0]);
        end else begin
            instr_mem_rdata_valid = 1'b0;
            instr_mem_tag_in      = '0;
            instr_mem_rdata       = '0;
        end
        #1;
        if (instr_mem_rdata_valid) void'(q.pop_front());
        if (instr_mem_addr_valid && instr_mem_addr_ready) begin
            req_t r;
            r.tag = instr_mem_tag_out;
            r.due = cyc + lat;
            q.push_back(r);
        end
        if (q.size() > max_out) max_out = q.size();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic do_reset(input int l);
        rstn                  = 1'b0;
        reset_vector          = 32'h0000_1000;
        instr_mem_addr_ready  = 1'b1;
        instr_mem_rdata_valid = 1'b0;
        instr_mem_tag_in      = '0;
        instr_mem_rdata       = '0;
        pc_exu                = '0;
        pc_load               = 1'b0;
        pipe_stall            = 1'b0;
        q.delete();
        lat     = l;
        max_out = 0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        #1;
    endtask

    initial begin
        logic [31:0] exp_tag;

        // ---- reset state ----
        do_reset(1);
        rstn = 1'b0;
        #1;
        check_val("rst_instr_valid", instr_valid, 0);
        check_val("rst_addr_valid", instr_mem_addr_valid, 0);
        check_val("rst_instr", instr, 0);
        check_val("rst_instr_tag", instr_tag, 0);
        rstn = 1'b1;
        #1;
        check_val("first_addr", instr_mem_addr, 16'h1000);
        check_val("first_tag_out", instr_mem_tag_out, 33'h0_0000_1000);
        check_val("first_addr_valid", instr_mem_addr_valid, 1);

        // ---- latency 1 streaming: head advances by 4 every cycle ----
        tick();
        check_val("lat1_addr2", instr_mem_addr, 16'h1004);
        check_val("lat1_empty", instr_valid, 0);
        tick();
        check_val("lat1_valid", instr_valid, 1);
        check_val("lat1_tag0", instr_tag, 32'h1000);
        check_val("lat1_instr0", instr, 32'h5A5A_1000);
        tick();
        check_val("lat1_tag1", instr_tag, 32'h1004);
        tick();
        check_val("lat1_tag2", instr_tag, 32'h1008);
        tick();
        check_val("lat1_tag3", instr_tag, 32'h100C);

        // ---- stall: FIFO fills to 4 then issue stops ----
        pipe_stall = 1'b1;
        repeat (3) tick();
        check_val("stall_addr_valid", instr_mem_addr_valid, 0);
        check_val("stall_inflight", q.size(), 0);
        repeat (2) tick();
        check_val("stall_hold_valid", instr_mem_addr_valid, 0);
        check_val("stall_hold_tag", instr_tag, 32'h100C);
        check_val("stall_hold_addr", instr_mem_addr, 16'h101C);
        pipe_stall = 1'b0;
        tick();
        check_val("unstall_tag", instr_tag, 32'h1010);
        check_val("unstall_resume", instr_mem_addr_valid, 1);
        tick();
        check_val("unstall_tag2", instr_tag, 32'h1014);
        check_val("unstall_addr", instr_mem_addr, 16'h1020);

        // ---- latency 3: at most 2 outstanding, no loss ----
        do_reset(3);
        tick();
        tick();
        check_val("lat3_pause", instr_mem_addr_valid, 0);
        tick();
        check_val("lat3_pause2", instr_mem_addr_valid, 0);
        tick();
        check_val("lat3_first_valid", instr_valid, 1);
        check_val("lat3_first_tag", instr_tag, 32'h1000);
        check_val("lat3_resume", instr_mem_addr_valid, 1);
        exp_tag = 32'h1004;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (instr_valid) begin
                check_val("lat3_seq", instr_tag, exp_tag);
                exp_tag = exp_tag + 32'd4;
            end
        end
        check_val("lat3_max_out_le2", (max_out <= 2), 1);
        check_val("lat3_progress", (exp_tag > 32'h1010), 1);

        // ---- redirect with 2 requests in flight ----
        do_reset(3);
        tick();
        tick();
        check_val("redir_inflight", q.size(), 2);
        pc_load = 1'b1;
        pc_exu  = 32'h0000_2003;
        tick();
        pc_load = 1'b0;
        #1;
        check_val("redir_addr", instr_mem_addr, 16'h2000);
        check_val("redir_no_credit", instr_mem_addr_valid, 0);
        tick();
        check_val("redir_drop0", instr_valid, 0);
        check_val("redir_tag_out", instr_mem_tag_out, 33'h1_0000_2000);
        check_val("redir_credit", instr_mem_addr_valid, 1);
        tick();
        check_val("redir_drop1", instr_valid, 0);
        for (int i = 0; i < 20 && !instr_valid; i++) tick();
        check_val("redir_valid", instr_valid, 1);
        check_val("redir_first_tag", instr_tag, 32'h2000);
        check_val("redir_first_instr", instr, 32'h5A5A_2000);

        // ---- redirect with matching response and pop in the same cycle ----
        do_reset(1);
        repeat (3) tick();
        check_val("mix_pre_valid", instr_valid, 1);
        check_val("mix_pre_resp", (q.size() == 1 && q[0].due <= cyc), 1);
        pc_load = 1'b1;
        pc_exu  = 32'h0000_3000;
        tick();
        pc_load = 1'b0;
        #1;
        check_val("mix_flush_valid", instr_valid, 0);
        check_val("mix_flush_instr", instr, 0);
        check_val("mix_flush_tag", instr_tag, 0);
        check_val("mix_addr_valid", instr_mem_addr_valid, 1);
        check_val("mix_tag_out", instr_mem_tag_out, 33'h1_0000_3000);

        // ---- memory not ready for 5 cycles ----
        instr_mem_addr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val("nrdy_addr", instr_mem_addr, 16'h3000);
            check_val("nrdy_tag", instr_mem_tag_out, 33'h1_0000_3000);
        end
        check_val("nrdy_empty", instr_valid, 0);
        instr_mem_addr_ready = 1'b1;
        tick();
        check_val("nrdy_next_addr", instr_mem_addr, 16'h3004);
        tick();
        check_val("nrdy_valid", instr_valid, 1);
        check_val("nrdy_tag_head", instr_tag, 32'h3000);

        // ---- reset mid-stream ----
        rstn = 1'b0;
        #1;
        check_val("mid_rst_valid", instr_valid, 0);
        check_val("mid_rst_instr", instr, 0);
        check_val("mid_rst_tag", instr_tag, 0);
        check_val("mid_rst_addr_valid", instr_mem_addr_valid, 0);
        q.delete();
        rstn = 1'b1;
        #1;
        check_val("restart_addr", instr_mem_addr, 16'h1000);
        check_val("restart_tag_out", instr_mem_tag_out, 33'h0_0000_1000);
        check_val("restart_valid", instr_mem_addr_valid, 1);
        tick();
        tick();
        check_val("restart_head", instr_tag, 32'h1000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ifu_prefetch.md
Name: ifu_prefetch

Overview:
Next-generation instruction fetch unit with a parametrised prefetch FIFO and several memory requests in flight at once. It decouples instruction-memory latency from decode stalls. Stale responses after an EXU redirect are discarded by an epoch bit carried in the request tag. It sits between the instruction memory and the decode stage.

Parameters:
FETCH_DEPTH, 4, prefetch FIFO entries (power of 2, >=2)
MAX_OUTSTANDING, 2, maximum issued-but-unreturned memory requests (>=1, <=FETCH_DEPTH)
TAG_WIDTH, XLEN+1, memory tag width; tag = {epoch, pc}

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
reset_vector  in  XLEN  PC loaded at reset
instr_mem_addr  out  INSTR_MEM_ADDR_WIDTH  fetch address, pc cropped to low bits
instr_mem_addr_valid  out  1  request valid
instr_mem_addr_ready  in  1  memory accepts request
instr_mem_tag_out  out  TAG_WIDTH  {epoch, pc} of request
instr_mem_rdata  in  INSTR_MEM_WIDTH  returned instruction
instr_mem_rdata_valid  in  1  response valid; in order, latency >=1
instr_mem_tag_in  in  TAG_WIDTH  tag returned with response
pc_exu  in  XLEN  redirect target
pc_load  in  1  redirect/flush strobe
pipe_stall  in  1  decode not accepting
instr  out  INSTR_LEN  head instruction
instr_valid  out  1  FIFO non-empty
instr_tag  out  XLEN  PC of head instruction

Behaviour:
- Reset (async, rstn=0): pc=reset_vector, epoch=0, inflight=0, FIFO empty, instr_valid=0, instr/instr_tag=0, instr_mem_addr_valid=0.
- Credit rule: instr_mem_addr_valid = ~pc_load & (inflight + fifo_count < FETCH_DEPTH) & (inflight < MAX_OUTSTANDING). This guarantees every accepted response has a free slot, so overflow is impossible.
- Issue: on valid & ready, inflight++ and pc += 4. If valid & ~ready, pc and tag hold stable.
- Response: on rdata_valid, inflight--. The response is pushed only if tag_in[TAG_WIDTH-1]==epoch and pc_load==0; otherwise it is dropped silently. Issue and response in the same cycle leave inflight unchanged.
- Pop: when instr_valid & ~pipe_stall, the head is dequeued. Push and pop in the same cycle keep fifo_count unchanged.
- Latency: a response pushed in cycle N appears on instr (if the FIFO was empty) with instr_valid=1 in cycle N+1. There is no bypass.
- Redirect (pc_load=1):
  - FIFO is cleared next cycle; instr_valid=0 next cycle.
  - epoch toggles; pc <= {pc_exu[XLEN-1:2], 2'b00}.
  - No request is issued that cycle, and any response that cycle is dropped.
  - inflight is not cleared. Old responses still return, are dropped by epoch mismatch, and release their credit.
- Priority: pc_load over pop/push/issue; reset over everything.
- Back-to-back redirects: each toggles epoch. Outstanding requests can span at most one toggle only when MAX_OUTSTANDING is bounded by memory latency. If outstanding requests could span two toggles, a single epoch bit could alias; in that case widen the epoch field in the tag (and TAG_WIDTH) accordingly.
- Wrap-around: pc increments modulo 2^XLEN. FIFO pointers wrap modulo FETCH_DEPTH, with a separate count of clog2(FETCH_DEPTH+1) bits. inflight is clog2(MAX_OUTSTANDING+1) bits.
- pipe_stall never blocks issue; only credits do.

Decomposition:
- Shared package: fetch_tag_t struct {epoch, pc}, and the FETCH_STEP=4 constant, alongside existing globals (XLEN, INSTR_LEN, INSTR_MEM_*).
- Sub-module fetch_fifo: synchronous FIFO, WIDTH/DEPTH params, push/pop/flush, count, empty/full. It holds {instr, pc}.
- Top level holds the pc/epoch/inflight registers and the credit logic.

Test Plan:
- Reset_vector=0x1000, ready=1, memory latency 1, no stall -> requests at 0x1000, 0x1004, 0x1008…; instr_valid from cycle 3; instr_tag increments by 4 every cycle.
- pipe_stall=1 held -> FIFO fills to 4, then addr_valid=0 with inflight=0 and count=4; release stall -> one pop per cycle, and issue resumes the cycle a credit frees.
- Latency 3, MAX_OUTSTANDING=2 -> inflight never exceeds 2; issue pauses until the first response; no FIFO overflow.
- Redirect pc_load with pc_exu=0x2003 while 2 requests are in flight -> both returns dropped; next request addr=0x2000 with flipped epoch; first instr_tag=0x2000.
- pc_load in the same cycle as a matching-epoch response and a pop -> response dropped, FIFO empty next cycle, instr_valid=0.
- addr_ready=0 for 5 cycles -> addr/tag stable, pc not incremented; resumes at the same address. rstn asserted mid-stream -> outputs zero immediately, then fetch restarts at reset_vector.
